// File: rtl/fifo_loop_pkg.sv
// Shared types and the expected-sequence step rule for the FIFO loop reader.
// Optional capture outputs are enabled with FIFO_LOOP_READER_CAPTURE_EN.
package fifo_loop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Working width of next_expected; callers truncate the result to FIFO_WIDTH,
  // which gives the modulo-2^FIFO_WIDTH wrap (supports FIFO_WIDTH up to 64).
  localparam int EXP_MAX_W = 64;

  // Step the expected word: +1, or +(loop_idx+1) in add mode.
  function automatic logic [EXP_MAX_W-1:0] next_expected(
    input logic [EXP_MAX_W-1:0] cur_exp,
    input logic [EXP_MAX_W-1:0] loop_idx,
    input logic                 add_mode
  );
    logic [EXP_MAX_W-1:0] step;
    step = add_mode ? (loop_idx + EXP_MAX_W'(1)) : EXP_MAX_W'(1);
    return cur_exp + step;
  endfunction

endpackage

// File: rtl/fifo_loop_expgen.sv
// Expected-sequence generator: owns word_idx, loop_idx and the expected word.
// With FIFO_LOOP_READER_CAPTURE_EN it also exports the global word index.
module fifo_loop_expgen
  import fifo_loop_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int NUM_LOOPS  = 3,
  parameter int ADD_MODE   = 0,
  localparam int WIDX_W    = $clog2(FIFO_DEPTH),
  localparam int LIDX_W    = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  advance,
  input  logic                  clear,
  output logic [FIFO_WIDTH-1:0] expected,
`ifdef FIFO_LOOP_READER_CAPTURE_EN
  output logic [$clog2(FIFO_DEPTH*NUM_LOOPS)-1:0] word_gidx,
`endif
  output logic                  last_word
);

  logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
  logic [LIDX_W-1:0]     loop_idx_q, loop_idx_d;
  logic [FIFO_WIDTH-1:0] expected_q, expected_d;
  logic                  word_wrap;

  assign word_wrap = (word_idx_q == WIDX_W'(FIFO_DEPTH - 1));
  assign last_word = word_wrap && (loop_idx_q == LIDX_W'(NUM_LOOPS - 1));
  assign expected  = expected_q;

`ifdef FIFO_LOOP_READER_CAPTURE_EN
  localparam int GIDX_W = $clog2(FIFO_DEPTH*NUM_LOOPS);
  // FIFO_DEPTH is a power of two, so loop:word concatenation is the global index.
  assign word_gidx = GIDX_W'({loop_idx_q, word_idx_q});
`endif

  // Next-state of counters and expected word; the step uses the pre-update loop_idx.
  always_comb begin
    word_idx_d = word_idx_q;
    loop_idx_d = loop_idx_q;
    expected_d = expected_q;
    if (clear) begin
      word_idx_d = '0;
      loop_idx_d = '0;
      expected_d = '0;
    end else if (advance) begin
      expected_d = FIFO_WIDTH'(next_expected(EXP_MAX_W'(expected_q),
                                             EXP_MAX_W'(loop_idx_q),
                                             ADD_MODE != 0));
      if (word_wrap) begin
        word_idx_d = '0;
        loop_idx_d = loop_idx_q + LIDX_W'(1);
      end else begin
        word_idx_d = word_idx_q + WIDX_W'(1);
      end
    end
  end

  // Counter and expected-word registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_idx_q <= '0;
      loop_idx_q <= '0;
      expected_q <= '0;
    end else begin
      word_idx_q <= word_idx_d;
      loop_idx_q <= loop_idx_d;
      expected_q <= expected_d;
    end
  end

endmodule

// File: rtl/fifo_loop_reader.sv
// FIFO loop reader: pops FIFO_DEPTH*NUM_LOOPS words per run and counts mismatches
// against a generated sequence. Define FIFO_LOOP_READER_CAPTURE_EN to add the
// first-mismatch capture outputs.
module fifo_loop_reader
  import fifo_loop_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int NUM_LOOPS  = 3,
  parameter int ADD_MODE   = 0,
  localparam int CNT_W     = $clog2(FIFO_DEPTH*NUM_LOOPS + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] pop_data,
  output logic                  pop,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef FIFO_LOOP_READER_CAPTURE_EN
  output logic [FIFO_WIDTH-1:0] first_err_data,
  output logic [FIFO_WIDTH-1:0] first_err_exp,
  output logic [$clog2(FIFO_DEPTH*NUM_LOOPS)-1:0] first_err_idx,
`endif
  output logic [CNT_W-1:0]      err_cnt
);

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  logic [FIFO_WIDTH-1:0] expected;
  logic                  last_word;
  logic                  start_ok;
  logic                  mismatch;

`ifdef FIFO_LOOP_READER_CAPTURE_EN
  localparam int GIDX_W = $clog2(FIFO_DEPTH*NUM_LOOPS);
  logic [FIFO_WIDTH-1:0] fe_data_q, fe_data_d;
  logic [FIFO_WIDTH-1:0] fe_exp_q, fe_exp_d;
  logic [GIDX_W-1:0]     fe_idx_q, fe_idx_d;
  logic [GIDX_W-1:0]     word_gidx;
`endif

  // Pop never looks at pop_data, so the FIFO handshake has no data-dependent path.
  assign pop      = (state_q == RUN) && !empty && !stall;
  assign start_ok = start && (state_q != RUN);
  assign mismatch = pop && (pop_data != expected);

  fifo_loop_expgen #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_WIDTH (FIFO_WIDTH),
    .NUM_LOOPS  (NUM_LOOPS),
    .ADD_MODE   (ADD_MODE)
  ) u_expgen (
    .clk       (clk),
    .rstn      (rstn),
    .advance   (pop),
    .clear     (start_ok),
    .expected  (expected),
`ifdef FIFO_LOOP_READER_CAPTURE_EN
    .word_gidx (word_gidx),
`endif
    .last_word (last_word)
  );

  // FSM transitions, status flags and error accounting for the next cycle.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (pop && last_word) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    if (start_ok) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (mismatch) begin
      err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
`ifdef FIFO_LOOP_READER_CAPTURE_EN
    fe_data_d = fe_data_q;
    fe_exp_d  = fe_exp_q;
    fe_idx_d  = fe_idx_q;
    if (start_ok) begin
      fe_data_d = '0;
      fe_exp_d  = '0;
      fe_idx_d  = '0;
    end else if (mismatch && !err_q) begin
      fe_data_d = pop_data;
      fe_exp_d  = expected;
      fe_idx_d  = word_gidx;
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
`ifdef FIFO_LOOP_READER_CAPTURE_EN
      fe_data_q <= '0;
      fe_exp_q  <= '0;
      fe_idx_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`ifdef FIFO_LOOP_READER_CAPTURE_EN
      fe_data_q <= fe_data_d;
      fe_exp_q  <= fe_exp_d;
      fe_idx_q  <= fe_idx_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`ifdef FIFO_LOOP_READER_CAPTURE_EN
  assign first_err_data = fe_data_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_idx  = fe_idx_q;
`endif

endmodule

// File: tb/tb_fifo_loop_reader.sv
// Bench for fifo_loop_reader: three instances (add-by-1, add-by-loop, 320-word wrap)
// each fed by a show-ahead FIFO model. Capture checks need FIFO_LOOP_READER_CAPTURE_EN.
module tb_fifo_loop_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       start_s [3];
  logic       stall_s [3];
  logic       gemp_s  [3];
  logic       pop_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       err_w   [3];
  logic       empty_w [3];
  logic [7:0] pd_w    [3];
  logic [7:0] mem     [3][320];
  int         popped  [3] = '{0, 0, 0};
  int         base    [3];
  int         len     [3];
  logic [3:0] ec_a, ec_b;
  logic [8:0] ec_c;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         b_tab [12] = '{0, 1, 2, 3, 4, 6, 8, 10, 12, 15, 18, 21};

`ifdef FIFO_LOOP_READER_CAPTURE_EN
  logic [7:0] fed_a, fee_a, fed_b, fee_b, fed_c, fee_c;
  logic [3:0] fei_a, fei_b;
  logic [8:0] fei_c;
`endif

  // Show-ahead FIFO models: head word valid while not empty, advance on pop.
  for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
    assign empty_w[gi] = ((popped[gi] - base[gi]) >= len[gi]) || gemp_s[gi];
    assign pd_w[gi]    = mem[gi][(popped[gi] - base[gi]) % 320];
    always @(posedge clk) if (pop_w[gi]) popped[gi] <= popped[gi] + 1;
  end

  fifo_loop_reader #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .NUM_LOOPS(3), .ADD_MODE(0)) u_a (
    .clk(clk), .rstn(rstn), .start(start_s[0]), .stall(stall_s[0]), .empty(empty_w[0]),
    .pop_data(pd_w[0]), .pop(pop_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
`ifdef FIFO_LOOP_READER_CAPTURE_EN
    .first_err_data(fed_a), .first_err_exp(fee_a), .first_err_idx(fei_a),
`endif
    .err_cnt(ec_a)
  );

  fifo_loop_reader #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .NUM_LOOPS(3), .ADD_MODE(1)) u_b (
    .clk(clk), .rstn(rstn), .start(start_s[1]), .stall(stall_s[1]), .empty(empty_w[1]),
    .pop_data(pd_w[1]), .pop(pop_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
`ifdef FIFO_LOOP_READER_CAPTURE_EN
    .first_err_data(fed_b), .first_err_exp(fee_b), .first_err_idx(fei_b),
`endif
    .err_cnt(ec_b)
  );

  fifo_loop_reader #(.FIFO_DEPTH(64), .FIFO_WIDTH(8), .NUM_LOOPS(5), .ADD_MODE(0)) u_c (
    .clk(clk), .rstn(rstn), .start(start_s[2]), .stall(stall_s[2]), .empty(empty_w[2]),
    .pop_data(pd_w[2]), .pop(pop_w[2]), .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]),
`ifdef FIFO_LOOP_READER_CAPTURE_EN
    .first_err_data(fed_c), .first_err_exp(fee_c), .first_err_idx(fei_c),
`endif
    .err_cnt(ec_c)
  );

  function automatic int ptr(input int k);
    return popped[k] - base[k];
  endfunction

  function automatic int get_ec(input int k);
    case (k)
      0:       return int'(ec_a);
      1:       return int'(ec_b);
      default: return int'(ec_c);
    endcase
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic load(input int k, input int n);
    base[k] = popped[k];
    len[k]  = n;
  endtask

  // Start a run and follow it to completion; done must rise the cycle after the final pop.
  task automatic run(input int k, input bit rnd, input bit restart_mid,
                     input bit start_at_final, input string tag);
    bit fin;
    int viol;
    int cyc;
    fin  = 1'b0;
    viol = 0;
    cyc  = 0;
    @(negedge clk); start_s[k] = 1'b1;
    @(negedge clk); start_s[k] = 1'b0;
    while (!fin && cyc < 2000) begin
      stall_s[k] = rnd && ($urandom_range(0, 1) == 1);
      gemp_s[k]  = rnd && ($urandom_range(0, 1) == 1);
      start_s[k] = (restart_mid && cyc == 4) ||
                   (start_at_final && ptr(k) == len[k] - 1 && !stall_s[k] && !gemp_s[k]);
      #1;
      if (cyc == 1) check({tag, "_busy_mid"}, busy_w[k], 1);
      if (pop_w[k] && (stall_s[k] || empty_w[k])) viol++;
      fin = pop_w[k] && (ptr(k) == len[k] - 1);
      @(negedge clk);
      cyc++;
    end
    start_s[k] = 1'b0;
    stall_s[k] = 1'b0;
    gemp_s[k]  = 1'b0;
    check({tag, "_finished"}, fin, 1);
    check({tag, "_done"}, done_w[k], 1);
    check({tag, "_busy_end"}, busy_w[k], 0);
    check({tag, "_pops"}, ptr(k), len[k]);
    if (rnd) check({tag, "_pop_gated"}, viol, 0);
    $display("run %s: pops=%0d err=%0d err_cnt=%0d", tag, ptr(k), err_w[k], get_ec(k));
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; stall_s[k] = 1'b0; gemp_s[k] = 1'b0; base[k] = 0; len[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_pop%0d", k), pop_w[k], 0);
      check($sformatf("rst_busy%0d", k), busy_w[k], 0);
      check($sformatf("rst_done%0d", k), done_w[k], 0);
      check($sformatf("rst_err%0d", k), err_w[k], 0);
      check($sformatf("rst_errcnt%0d", k), get_ec(k), 0);
    end
    rstn = 1'b1;

    // Add-by-1 clean run: 0..11.
    for (int i = 0; i < 12; i++) mem[0][i] = 8'(i);
    load(0, 12);
    run(0, 0, 0, 0, "a_clean");
    check("a_clean_err", err_w[0], 0);
    check("a_clean_errcnt", get_ec(0), 0);

    // Add-by-loop clean run.
    for (int i = 0; i < 12; i++) mem[1][i] = 8'(b_tab[i]);
    load(1, 12);
    run(1, 0, 0, 0, "b_clean");
    check("b_clean_err", err_w[1], 0);
    check("b_clean_errcnt", get_ec(1), 0);

    // Word 5 corrupted (6 -> 7); start coincides with the final pop and is ignored.
    mem[1][5] = 8'd7;
    load(1, 12);
    run(1, 0, 0, 1, "b_bad");
    check("b_bad_err", err_w[1], 1);
    check("b_bad_errcnt", get_ec(1), 1);

    // Random empty/stall throttling plus a start pulse mid-run that must be ignored.
    load(0, 12);
    run(0, 1, 1, 0, "a_rnd");
    check("a_rnd_err", err_w[0], 0);
    check("a_rnd_errcnt", get_ec(0), 0);

    // 320 words: expected crosses 255 -> 0 without error.
    for (int i = 0; i < 320; i++) mem[2][i] = 8'(i % 256);
    load(2, 320);
    run(2, 0, 0, 0, "c_wrap");
    check("c_wrap_err", err_w[2], 0);
    check("c_wrap_errcnt", get_ec(2), 0);

    // Mismatches at words 2 and 7.
    mem[0][2] = 8'hA2;
    mem[0][7] = 8'h77;
    load(0, 12);
    run(0, 0, 0, 0, "a_two");
    check("a_two_err", err_w[0], 1);
    check("a_two_errcnt", get_ec(0), 2);
`ifdef FIFO_LOOP_READER_CAPTURE_EN
    check("cap_data", fed_a, 8'hA2);
    check("cap_exp", fee_a, 2);
    check("cap_idx", fei_a, 2);
`endif

    // Reset at word 5 of a run that already has one mismatch.
    load(0, 12);
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    for (int i = 0; i < 50 && ptr(0) < 5; i++) @(negedge clk);
    check("mid_reach5", ptr(0) >= 5, 1);
    check("mid_err_pre", err_w[0], 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_pop", pop_w[0], 0);
    check("mid_rst_busy", busy_w[0], 0);
    check("mid_rst_done", done_w[0], 0);
    check("mid_rst_err", err_w[0], 0);
    check("mid_rst_errcnt", get_ec(0), 0);
`ifdef FIFO_LOOP_READER_CAPTURE_EN
    check("mid_rst_capdata", fed_a, 0);
    check("mid_rst_capidx", fei_a, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) mem[0][i] = 8'(i);
    load(0, 12);
    run(0, 0, 0, 0, "a_after_rst");
    check("a_after_rst_err", err_w[0], 0);
    check("a_after_rst_errcnt", get_ec(0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
